// File: rtl/hex_display_scanner.sv
// hex_display_scanner
//   Drives the six 7-segment digits. One hex-to-segment decoder is shared by
//   all digits: a round-robin scan visits one digit per slot, decodes it and
//   latches the glyph into that digit's registered, active-low segment slice.
//
//   Slot sequence: WAIT (REFRESH_DIV cycles) -> SAMPLE (1) -> LATCH (1).
//
//   Ports
//     clk, reset   : system clock, synchronous active-high reset
//     wr_en        : write request (held by requester until accepted)
//     wr_digit     : target digit index, out-of-range indices are dropped
//     wr_value     : 4-bit hex value to store
//     wr_ready     : high in WAIT and LATCH, low in SAMPLE and during reset
//     blank_mask   : bit i forces digit i dark
//     seg_out      : digit i at [7i+6:7i], active low, bit0=a .. bit6=g
//     scan_index   : digit currently being serviced
//     frame_done   : one-cycle pulse after the last digit of a frame latches
//     dbg_state    : current scan state (0=WAIT, 1=SAMPLE, 2=LATCH)
//
//   Handshake: a write transfers on every rising edge where wr_en && wr_ready
//   are both high; the value register updates at that edge. While wr_ready is
//   low the request is ignored and must be held.
module hex_display_scanner #(
    parameter int NUM_DIGITS    = 6,
    parameter int REFRESH_DIV   = 50000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [2:0]              wr_digit,
    input  logic [3:0]              wr_value,
    output logic                    wr_ready,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic [2:0]              scan_index,
    output logic                    frame_done,
    output logic [1:0]              dbg_state
);

    localparam int              DIV_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    localparam logic [2:0]      LAST_IDX = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_SAMPLE = 2'd1,
        S_LATCH  = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [2:0]              idx_q, idx_d;
    logic [3:0]              val_q [NUM_DIGITS];
    logic [3:0]              val_d [NUM_DIGITS];
    logic [3:0]              smp_val_q, smp_val_d;
    logic                    smp_dark_q, smp_dark_d;
    logic [7*NUM_DIGITS-1:0] seg_q, seg_d;
    logic                    fd_q, fd_d;
    logic                    lz_all;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        logic [6:0] g;
        case (v)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h27;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Reset is folded in so a requester never sees a handshake while the
    // block is being cleared.
    assign wr_ready   = !reset && (state_q != S_SAMPLE);
    assign seg_out    = seg_q;
    assign scan_index = idx_q;
    assign frame_done = fd_q;
    assign dbg_state  = state_q;

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        idx_d      = idx_q;
        val_d      = val_q;
        smp_val_d  = smp_val_q;
        smp_dark_d = smp_dark_q;
        seg_d      = seg_q;
        fd_d       = 1'b0;

        // Digit idx_q is a leading zero when it and every more-significant
        // digit hold zero. The mask deliberately plays no part here.
        lz_all = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx_q) && val_q[j] != 4'd0) begin
                lz_all = 1'b0;
            end
        end

        case (state_q)
            S_WAIT: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_SAMPLE: begin
                smp_val_d  = val_q[idx_q];
                smp_dark_d = blank_mask[idx_q] ||
                             ((BLANK_LEADING != 0) && (idx_q != 3'd0) && lz_all);
                state_d    = S_LATCH;
            end
            S_LATCH: begin
                // Uses the SAMPLE snapshot, so a write landing now is only
                // shown on this digit's next visit.
                seg_d[7*int'(idx_q) +: 7] = smp_dark_q ? 7'h7F : hex_glyph(smp_val_q);
                if (idx_q == LAST_IDX) begin
                    idx_d = 3'd0;
                    fd_d  = 1'b1;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
                state_d = S_WAIT;
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase

        if (wr_en && wr_ready && (int'(wr_digit) < NUM_DIGITS)) begin
            val_d[wr_digit] = wr_value;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_WAIT;
            div_q      <= '0;
            idx_q      <= 3'd0;
            val_q      <= '{default: 4'd0};
            smp_val_q  <= 4'd0;
            smp_dark_q <= 1'b0;
            seg_q      <= '1;
            fd_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            idx_q      <= idx_d;
            val_q      <= val_d;
            smp_val_q  <= smp_val_d;
            smp_dark_q <= smp_dark_d;
            seg_q      <= seg_d;
            fd_q       <= fd_d;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Bench for hex_display_scanner with NUM_DIGITS=6, REFRESH_DIV=4,
// BLANK_LEADING=1. The model tracks time as cycles since reset release:
// slot = t/6, phase = t%6 (phase 4 samples, phase 5 latches).
module tb_hex_display_scanner;

    localparam int ND   = 6;
    localparam int DIV  = 4;
    localparam int SLOT = DIV + 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_en;
    logic [2:0]      wr_digit;
    logic [3:0]      wr_value;
    logic            wr_ready;
    logic [ND-1:0]   blank_mask;
    logic [7*ND-1:0] seg_out;
    logic [2:0]      scan_index;
    logic            frame_done;
    logic [1:0]      dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    hex_display_scanner #(
        .NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_LEADING(1)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_digit(wr_digit),
        .wr_value(wr_value), .wr_ready(wr_ready), .blank_mask(blank_mask),
        .seg_out(seg_out), .scan_index(scan_index), .frame_done(frame_done),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
    };

    // ---------------- model ----------------
    bit         m_valid = 1'b0;
    int         m_t = 0;
    logic [3:0] m_val [ND];
    logic [6:0] m_seg [ND];
    logic [6:0] m_pend = 7'h7F;

    function automatic logic [6:0] model_glyph(input int d, input logic [ND-1:0] mask);
        bit lz;
        lz = (d > 0);
        for (int j = d; j < ND; j++) if (m_val[j] != 4'd0) lz = 1'b0;
        if (mask[d] || lz) return 7'h7F;
        return glyph_tab[m_val[d]];
    endfunction

    function automatic logic [7*ND-1:0] model_seg_vec();
        logic [7*ND-1:0] v;
        for (int i = 0; i < ND; i++) v[7*i +: 7] = m_seg[i];
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1'b1;
            m_t = 0;
            for (int i = 0; i < ND; i++) begin
                m_val[i] = 4'd0;
                m_seg[i] = 7'h7F;
            end
        end else if (m_valid) begin
            int p, d;
            p = m_t % SLOT;
            d = (m_t / SLOT) % ND;
            if (p == DIV)     m_pend = model_glyph(d, blank_mask);
            if (p == DIV + 1) m_seg[d] = m_pend;
            if (wr_en && p != DIV && int'(wr_digit) < ND) m_val[wr_digit] = wr_value;
            m_t++;
        end
    end

    // ---------------- compare ----------------
    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0d time=%0t", name, got, exp, m_t, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("seg_out", 64'(seg_out), 64'(model_seg_vec()));
            chk("scan_index", 64'(scan_index), 64'((m_t / SLOT) % ND));
            chk("frame_done", 64'(frame_done), 64'((m_t > 0) && (m_t % (ND * SLOT) == 0)));
            chk("wr_ready", 64'(wr_ready), 64'(!reset && (m_t % SLOT != DIV)));
        end
    end

    // ---------------- drivers ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_neg_t(input int n);
        bit ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (m_t == n) ok = 1'b1;
        end
        chk("wait_t_timeout", 64'(ok), 64'd1);
    endtask

    // Returns at posedge+1 with the given phase (and digit, if >= 0) starting.
    task automatic wait_phase(input int p, input int d);
        bit ok = 1'b0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (m_t % SLOT == p && (d < 0 || (m_t / SLOT) % ND == d)) ok = 1'b1;
            else step(1);
        end
        chk("wait_phase_timeout", 64'(ok), 64'd1);
    endtask

    // Enter at posedge+1; holds the request until it transfers.
    task automatic do_write(input int d, input int v, output int waited);
        bit ok = 1'b0;
        wr_en = 1'b1;
        wr_digit = 3'(d);
        wr_value = 4'(v);
        waited = 0;
        for (int k = 0; k < 10 && !ok; k++) begin
            @(negedge clk);
            if (wr_ready === 1'b1) ok = 1'b1;
            else waited++;
            @(posedge clk);
            #1;
        end
        wr_en = 1'b0;
        chk("wr_timeout", 64'(ok), 64'd1);
    endtask

    function automatic logic [7*ND-1:0] segs(input logic [6:0] d5, d4, d3, d2, d1, d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    initial begin
        int waited;
        int cnt;
        bit seen;
        reset = 1'b1;
        wr_en = 1'b0;
        wr_digit = 3'd0;
        wr_value = 4'd0;
        blank_mask = '0;

        // reset state
        step(3);
        @(negedge clk);
        chk("rst_seg_dark", 64'(seg_out), 64'(segs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F)));
        chk("rst_wr_ready", 64'(wr_ready), 64'd0);
        step(1);
        reset = 1'b0;

        @(negedge clk);
        chk("post_rst_ready", 64'(wr_ready), 64'd1);
        wait_neg_t(5);
        chk("d0_dark_t5", 64'(seg_out[6:0]), 64'h7F);
        wait_neg_t(6);
        chk("d0_zero_t6", 64'(seg_out[6:0]), 64'h40);
        wait_neg_t(35);
        chk("fd_low_t35", 64'(frame_done), 64'd0);
        wait_neg_t(36);
        chk("fd_pulse_t36", 64'(frame_done), 64'd1);

        // writes with leading-zero suppression
        step(1);
        do_write(3, 4'hA, waited);
        do_write(0, 4'h2, waited);
        step(45);
        @(negedge clk);
        chk("frame_a", 64'(seg_out), 64'(segs(7'h7F, 7'h7F, 7'h08, 7'h40, 7'h40, 7'h24)));

        // mask digit 3; digits 1-2 are still not leading zeros
        step(1);
        blank_mask = 6'b001000;
        step(40);
        @(negedge clk);
        chk("frame_mask", 64'(seg_out), 64'(segs(7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h24)));
        step(1);
        blank_mask = '0;
        step(40);

        // request held across SAMPLE
        wait_phase(DIV, -1);
        do_write(1, 5, waited);
        chk("sample_stall_cycles", 64'(waited), 64'd1);
        step(45);
        @(negedge clk);
        chk("frame_hold", 64'(seg_out), 64'(segs(7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12, 7'h24)));

        // out-of-range digit completes but changes nothing
        step(1);
        do_write(7, 9, waited);
        step(2 * ND * SLOT);
        @(negedge clk);
        chk("bad_digit", 64'(seg_out), 64'(segs(7'h7F, 7'h7F, 7'h08, 7'h40, 7'h12, 7'h24)));

        // reset during LATCH of digit 4
        step(1);
        wait_phase(DIV + 1, 4);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_dark", 64'(seg_out), 64'(segs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F)));
        chk("mid_rst_idx", 64'(scan_index), 64'd0);
        cnt = 1;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) seen = 1'b1;
            else cnt++;
        end
        chk("mid_rst_fd_delay", 64'(cnt), 64'd36);
        // values cleared: only digit 0 shows a zero
        chk("mid_rst_vals", 64'(seg_out), 64'(segs(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40)));

        step(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
